param_traffic_light_controller: RTL and testbench

//  Parametrised N-phase traffic light controller; successor to the fixed 4-approach controller.

---
 rtl/param_traffic_light_controller.sv | 190 +++++++++++++++++++
 tb/tb_param_traffic_light_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_traffic_light_controller.sv
// rtl/param_traffic_light_controller.sv - demand-actuated N-phase traffic light controller
//
// Purpose: serves NUM_PHASES light groups in round-robin order, only on demand,
//   resting in green when nobody else is waiting. Green/yellow/all-red durations are
//   counted in ticks of an internal prescaler. All outputs are registered.
// Optional feature: define TLC_PED_EN to add a pedestrian WALK phase (ped_req/ped_walk).
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high
//   phase_req    - per-phase demand, level or single-cycle pulse
//   light        - phase i lamps at light[3i+2:3i]: 100 red, 010 yellow, 001 green
//   active_phase - phase currently owning, or last owning, green
//   ctrl_state   - 00 GREEN, 01 YELLOW, 10 ALL_RED, 11 WALK
//   ped_req      - pedestrian request (TLC_PED_EN only)
//   ped_walk     - walk lamp (TLC_PED_EN only)
module param_traffic_light_controller #(
    parameter int NUM_PHASES = 4,
    parameter int TICK_DIV   = 1,
    parameter int GREEN_T    = 7,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int PED_T      = 5,
    parameter int CNT_W      = 8,
    localparam int PH_W      = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PHASES-1:0]   phase_req,
    output logic [3*NUM_PHASES-1:0] light,
    output logic [PH_W-1:0]         active_phase,
    output logic [1:0]              ctrl_state
`ifdef TLC_PED_EN
    ,
    input  logic                    ped_req,
    output logic                    ped_walk
`endif
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_ALL_RED = 2'b10,
        ST_WALK    = 2'b11
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [PH_W-1:0]           r_active;
    logic [PH_W-1:0]           w_next_active;
    logic [NUM_PHASES-1:0]     r_pend;
    logic [NUM_PHASES-1:0]     w_pend_set;
    logic [NUM_PHASES-1:0]     w_pend_clr;
    logic [NUM_PHASES-1:0]     w_active_oh;
    logic [CNT_W-1:0]          r_presc;
    logic [CNT_W-1:0]          r_timer;
    logic [CNT_W-1:0]          w_load;
    logic [3*NUM_PHASES-1:0]   r_light;
    logic [3*NUM_PHASES-1:0]   w_next_light;
    logic                      w_tick;
    logic                      w_expire;
    logic                      w_other_pend;
    logic                      w_state_change;
    logic                      w_ped_req;
    logic                      r_ped_pend;

`ifdef TLC_PED_EN
    assign w_ped_req = ped_req;
`else
    assign w_ped_req = 1'b0;
`endif

    // First pending phase after cur, wrapping; cur itself is checked last so a
    // request that arrived for it outside green re-greens it. No demand -> cur.
    function automatic logic [PH_W-1:0] f_next_phase(input logic [PH_W-1:0]       cur,
                                                     input logic [NUM_PHASES-1:0] pend);
        logic [PH_W-1:0] sel;
        logic [PH_W-1:0] cand;
        logic            found;
        int              idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            idx = int'(cur) + k;
            if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
            cand = idx[PH_W-1:0];
            if (!found && pend[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return sel;
    endfunction

    assign w_tick       = (r_presc == CNT_W'(TICK_DIV - 1));
    assign w_expire     = w_tick && (r_timer == '0);
    assign w_active_oh  = NUM_PHASES'(1) << r_active;
    assign w_other_pend = |(r_pend & ~w_active_oh);

    always_comb begin
        w_next_state  = r_state;
        w_next_active = r_active;
        case (r_state)
            ST_GREEN:   if (w_expire && (w_other_pend || r_ped_pend)) w_next_state = ST_YELLOW;
            ST_YELLOW:  if (w_expire) w_next_state = ST_ALL_RED;
            ST_ALL_RED: begin
                if (w_expire) begin
                    if (r_ped_pend) begin
                        w_next_state = ST_WALK;
                    end else begin
                        w_next_state  = ST_GREEN;
                        w_next_active = f_next_phase(r_active, r_pend);
                    end
                end
            end
            default:    if (w_expire) w_next_state = ST_ALL_RED;
        endcase
    end

    assign w_state_change = (w_next_state != r_state);

    always_comb begin
        w_load = CNT_W'(ALLRED_T - 1);
        case (w_next_state)
            ST_GREEN:  w_load = CNT_W'(GREEN_T - 1);
            ST_YELLOW: w_load = CNT_W'(YELLOW_T - 1);
            ST_WALK:   w_load = CNT_W'(PED_T - 1);
            default:   w_load = CNT_W'(ALLRED_T - 1);
        endcase
    end

    // Requests for the phase already in green are dropped; the green-entry clear
    // is applied after the set so it wins on a same-cycle collision.
    always_comb begin
        w_pend_set = phase_req;
        if (r_state == ST_GREEN) w_pend_set = phase_req & ~w_active_oh;
        w_pend_clr = '0;
        if (w_next_state == ST_GREEN && r_state != ST_GREEN)
            w_pend_clr = NUM_PHASES'(1) << w_next_active;
    end

    always_comb begin
        w_next_light = {NUM_PHASES{3'b100}};
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (w_next_active == PH_W'(i)) begin
                if (w_next_state == ST_GREEN)  w_next_light[3*i +: 3] = 3'b001;
                if (w_next_state == ST_YELLOW) w_next_light[3*i +: 3] = 3'b010;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ALL_RED;
            r_active   <= '0;
            r_pend     <= '0;
            r_presc    <= '0;
            r_timer    <= CNT_W'(ALLRED_T - 1);
            r_light    <= {NUM_PHASES{3'b100}};
            r_ped_pend <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_active <= w_next_active;
            r_light  <= w_next_light;
            r_pend   <= (r_pend | w_pend_set) & ~w_pend_clr;
            if (w_state_change) begin
                r_presc <= '0;
                r_timer <= w_load;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
                if (w_tick && r_timer != '0) r_timer <= r_timer - CNT_W'(1);
            end
            if (w_next_state == ST_WALK && r_state != ST_WALK) r_ped_pend <= 1'b0;
            else if (w_ped_req)                                r_ped_pend <= 1'b1;
        end
    end

`ifdef TLC_PED_EN
    logic r_ped_walk;
    always_ff @(posedge clk) begin
        if (reset) r_ped_walk <= 1'b0;
        else       r_ped_walk <= (w_next_state == ST_WALK);
    end
    assign ped_walk = r_ped_walk;
`endif

    assign light        = r_light;
    assign active_phase = r_active;
    assign ctrl_state   = r_state;

endmodule

// File: tb/tb_param_traffic_light_controller.sv
// tb/tb_param_traffic_light_controller.sv - directed self-checking bench for the traffic light controller
module tb_param_traffic_light_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  phase_req;
    logic [11:0] light;
    logic [1:0]  active_phase;
    logic [1:0]  ctrl_state;
    logic [3:0]  req4;
    logic [11:0] light4;
    logic [1:0]  active4;
    logic [1:0]  state4;
`ifdef TLC_PED_EN
    logic        ped_req;
    logic        ped_walk;
    logic        ped_req4;
    logic        ped_walk4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    param_traffic_light_controller dut (
        .clk          (clk),
        .reset        (reset),
        .phase_req    (phase_req),
        .light        (light),
        .active_phase (active_phase),
        .ctrl_state   (ctrl_state)
`ifdef TLC_PED_EN
        , .ped_req    (ped_req),
        .ped_walk     (ped_walk)
`endif
    );

    param_traffic_light_controller #(.TICK_DIV(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .phase_req    (req4),
        .light        (light4),
        .active_phase (active4),
        .ctrl_state   (state4)
`ifdef TLC_PED_EN
        , .ped_req    (ped_req4),
        .ped_walk     (ped_walk4)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_light(input string tag, input int n, input logic [11:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            check_eq(tag, {20'd0, light}, {20'd0, exp});
        end
    endtask

    task automatic expect_light4(input string tag, input int n, input logic [11:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            check_eq(tag, {20'd0, light4}, {20'd0, exp});
        end
    endtask

    task automatic do_reset();
        phase_req = '0;
        req4      = '0;
        reset     = 1'b1;
        step();
        step();
        check_eq("rst_light",  {20'd0, light}, 32'h924);
        check_eq("rst_state",  {30'd0, ctrl_state}, 32'd2);
        check_eq("rst_active", {30'd0, active_phase}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        phase_req = '0;
        req4      = '0;
`ifdef TLC_PED_EN
        ped_req   = 1'b0;
        ped_req4  = 1'b0;
`endif

        // 1: no demand -> phase0 green after one all-red cycle, then rest
        do_reset();
        check_eq("t1_post_rst", {20'd0, light}, 32'h924);
        expect_light("t1_green", 1, 12'h921);
        check_eq("t1_state", {30'd0, ctrl_state}, 32'd0);
        expect_light("t1_rest", 20, 12'h921);
        check_eq("t1_rest_state", {30'd0, ctrl_state}, 32'd0);

        // 2: req[2] pulse -> full phase0 cycle then phase2 green
        do_reset();
        expect_light("t2_g0", 3, 12'h921);
        phase_req = 4'b0100;
        expect_light("t2_g0", 1, 12'h921);
        phase_req = '0;
        expect_light("t2_g0", 3, 12'h921);
        expect_light("t2_y0", 3, 12'h922);
        check_eq("t2_y_state", {30'd0, ctrl_state}, 32'd1);
        expect_light("t2_ar", 1, 12'h924);
        check_eq("t2_ar_state", {30'd0, ctrl_state}, 32'd2);
        expect_light("t2_g2", 1, 12'h864);
        check_eq("t2_active", {30'd0, active_phase}, 32'd2);
        expect_light("t2_rest", 15, 12'h864);

        // 3: req[1] and req[3] together -> 1 then 3, then rest on 3
        do_reset();
        expect_light("t3_g0", 1, 12'h921);
        phase_req = 4'b1010;
        expect_light("t3_g0", 1, 12'h921);
        phase_req = '0;
        expect_light("t3_g0", 5, 12'h921);
        expect_light("t3_y0", 3, 12'h922);
        expect_light("t3_ar", 1, 12'h924);
        expect_light("t3_g1", 7, 12'h90C);
        check_eq("t3_active1", {30'd0, active_phase}, 32'd1);
        expect_light("t3_y1", 3, 12'h914);
        expect_light("t3_ar", 1, 12'h924);
        expect_light("t3_g3", 1, 12'h324);
        check_eq("t3_active3", {30'd0, active_phase}, 32'd3);
        expect_light("t3_rest", 15, 12'h324);

        // 4: reset during phase1 yellow with demand pending -> clean restart on phase0
        do_reset();
        expect_light("t4_g0", 1, 12'h921);
        phase_req = 4'b0010;
        expect_light("t4_g0", 1, 12'h921);
        phase_req = '0;
        expect_light("t4_g0", 5, 12'h921);
        expect_light("t4_y0", 3, 12'h922);
        expect_light("t4_ar", 1, 12'h924);
        expect_light("t4_g1", 1, 12'h90C);
        phase_req = 4'b0100;
        expect_light("t4_g1", 1, 12'h90C);
        phase_req = '0;
        expect_light("t4_g1", 5, 12'h90C);
        expect_light("t4_y1", 1, 12'h914);
        phase_req = 4'b1101;
        expect_light("t4_y1", 1, 12'h914);
        phase_req = '0;
        reset = 1'b1;
        step();
        check_eq("t4_rst_light",  {20'd0, light}, 32'h924);
        check_eq("t4_rst_state",  {30'd0, ctrl_state}, 32'd2);
        check_eq("t4_rst_active", {30'd0, active_phase}, 32'd0);
        reset = 1'b0;
        expect_light("t4_g0_after", 1, 12'h921);
        expect_light("t4_rest", 15, 12'h921);
        check_eq("t4_rest_active", {30'd0, active_phase}, 32'd0);

        // 5: TICK_DIV=4 -> all-red 4, green 28, yellow 12, all-red 4
        do_reset();
        check_eq("t5_rst_light4", {20'd0, light4}, 32'h924);
        expect_light4("t5_ar_init", 3, 12'h924);
        expect_light4("t5_g0", 2, 12'h921);
        req4 = 4'b0010;
        expect_light4("t5_g0", 1, 12'h921);
        req4 = '0;
        expect_light4("t5_g0", 25, 12'h921);
        expect_light4("t5_y0", 12, 12'h922);
        expect_light4("t5_ar", 4, 12'h924);
        expect_light4("t5_g1", 1, 12'h90C);
        check_eq("t5_active4", {30'd0, active4}, 32'd1);

`ifdef TLC_PED_EN
        // 6: pedestrian + req[1] -> yellow, all-red, walk 5, all-red, phase1 green
        do_reset();
        expect_light("t6_g0", 1, 12'h921);
        ped_req   = 1'b1;
        phase_req = 4'b0010;
        expect_light("t6_g0", 1, 12'h921);
        ped_req   = 1'b0;
        phase_req = '0;
        expect_light("t6_g0", 5, 12'h921);
        expect_light("t6_y0", 3, 12'h922);
        expect_light("t6_ar", 1, 12'h924);
        check_eq("t6_walk_off", {31'd0, ped_walk}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t6_walk_light", {20'd0, light}, 32'h924);
            check_eq("t6_walk_lamp",  {31'd0, ped_walk}, 32'd1);
            check_eq("t6_walk_state", {30'd0, ctrl_state}, 32'd3);
        end
        expect_light("t6_ar2", 1, 12'h924);
        check_eq("t6_walk_end", {31'd0, ped_walk}, 32'd0);
        expect_light("t6_g1", 1, 12'h90C);
        check_eq("t6_active", {30'd0, active_phase}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
